serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
Downstream consumer of the serial bit stream produced by the shift register stage. It samples one bit per qualified clock, frames start/data/parity/stop bits, and reassembles each frame into a parallel word. The word is handed to the next stage over a valid/ready handshake with a one-deep holding register. It flags parity errors, framing errors and overflow.

Parameters:
DATA_W, 8, number of data bits per frame, sent LSB-first; legal range 1..16.
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
serial  input  1  incoming serial bit; the line idles high.
bit_en  input  1  qualifier; serial is sampled only on edges where bit_en = 1.
out_data  output  DATA_W  received word, held stable while out_valid = 1.
out_valid  output  1  a word is available in the holding register.
out_ready  input  1  consumer accepts the word on an edge where out_valid & out_ready.
parity_err  output  1  one-cycle pulse; the frame is dropped.
frame_err  output  1  one-cycle pulse when the stop bit is 0; the frame is dropped.
overflow  output  1  sticky; a good frame was dropped because the holding register was full. Cleared only by reset.

Behaviour:
- Reset (synchronous, wins over everything):
  - state = IDLE; bit counter = 0; shift register = 0.
  - out_data = 0; out_valid = 0; parity_err = 0; frame_err = 0; overflow = 0.
  - Reset in the middle of a frame discards the partial frame.
- States: IDLE, DATA, PARITY, STOP. All transitions and samples occur only on edges with bit_en = 1. With bit_en = 0 the receiver state is frozen; the handshake logic still runs.
- IDLE:
  - serial = 0 → DATA, bit counter = 0.
  - serial = 1 → stay in IDLE.
- DATA:
  - Each sampled bit is stored at position counter, so the first data bit becomes bit 0.
  - After the DATA_W-th bit: → PARITY if PARITY_EN = 1, otherwise → STOP.
- PARITY:
  - Sample the parity bit and → STOP.
  - Error condition: XOR of the data bits and the parity bit must equal PARITY_ODD; a mismatch marks the frame bad.
- STOP: sample the stop bit, then → IDLE in all cases.
  - A stop bit of 0 is not reinterpreted as a new start bit.
- Frame outcome, evaluated on the stop-bit sample edge; outputs change in the following cycle:
  - stop = 0: frame_err pulses high for 1 cycle and the word is dropped. frame_err takes priority over parity_err, so only frame_err pulses.
  - Stop = 1 with a parity mismatch: parity_err pulses for 1 cycle and the word is dropped.
  - Good frame with the holding register empty, or being emptied on this same edge (out_valid & out_ready): out_data is loaded and out_valid = 1.
  - Good frame with out_valid = 1 and out_ready = 0: the new word is dropped, out_data is unchanged, and overflow is set to 1.
- Handshake:
  - out_valid drops after an edge with out_valid & out_ready, unless a new word loads on that same edge.
  - out_data and out_valid never change while out_valid = 1 and out_ready = 0.
- Latency: out_valid rises in the cycle right after the stop-bit sample edge.

Test Plan:
(All scenarios use DATA_W = 8, PARITY_EN = 1, PARITY_ODD = 0.)
1. Good frame: out_ready = 1, bit_en = 1 every cycle, serial = 0, 1,0,1,0,0,1,0,1, 0, 1 (byte 0xA5) → out_data = 0xA5, out_valid high for one cycle after the stop edge, no errors.
2. Parity error: same frame as scenario 1 but with parity bit 1 → parity_err pulses for 1 cycle, out_valid stays 0; a following good frame carrying 0x0F is received correctly.
3. Framing error: 0xA5 frame with stop bit 0, then serial = 1 → frame_err pulses for 1 cycle, out_valid stays 0, state is IDLE; the next good 0x3C frame gives out_data = 0x3C.
4. Overflow: out_ready = 0; send 0x3C, then 0x81 → out_data stays 0x3C and overflow = 1; raising out_ready for 1 cycle drops out_valid while overflow stays 1.
5. Gapped stream: bit_en high on alternate cycles, serial changes only on enabled cycles, frame 0xA5 → same result as scenario 1; the state is frozen on disabled cycles.
6. Reset mid-frame: assert reset after 4 data bits, then send a full 0x0F frame → all outputs are 0 during reset; afterwards out_data = 0x0F with no errors.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// Output handshake bundle for serial_frame_rx: parallel word plus valid/ready.
// The receiver uses the master side; the downstream consumer uses the slave side.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), optional
// parity bit and a stop bit. Each frame is reassembled into a word held in a
// one-deep register and offered downstream over valid/ready. Bad frames pulse
// parity_err or frame_err; a good frame arriving while the holding register is
// still occupied is dropped and sets the sticky overflow flag.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                serial,
  input  logic                bit_en,
  serial_frame_rx_if.master   out_if,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bad_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              overflow_q;

  // Returns 1 when data plus received parity bit do not match the configured sense.
  function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
    return ((^d) ^ p) != 1'(PARITY_ODD);
  endfunction

  // Receiver FSM, holding register and status flags; the handshake side keeps
  // running on edges where bit_en is low while the frame state stays frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (out_valid_q && out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!serial) begin
              state_q   <= DATA;
              cnt_q     <= '0;
              shift_q   <= '0;
              par_bad_q <= 1'b0;
            end
          end
          DATA: begin
            shift_q <= shift_q | (DATA_W'(serial) << cnt_q);
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            par_bad_q <= parity_bad(shift_q, serial);
            state_q   <= STOP;
          end
          STOP: begin
            // A low stop bit is only a framing error, never a new start bit.
            state_q <= IDLE;
            if (!serial) begin
              frame_err_q <= 1'b1;
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
            end else if (!out_valid_q || out_if.out_ready) begin
              out_data_q  <= shift_q;
              out_valid_q <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign parity_err       = parity_err_q;
  assign frame_err        = frame_err_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, even parity).
module tb_serial_frame_rx;

  logic clk;
  logic reset;
  logic serial;
  logic bit_en;
  logic parity_err;
  logic frame_err;
  logic overflow;

  int n_cmp;
  int n_bad;

  serial_frame_rx_if #(.DATA_W(8)) rx_if ();

  serial_frame_rx #(
    .DATA_W(8),
    .PARITY_EN(1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .serial    (serial),
    .bit_en    (bit_en),
    .out_if    (rx_if.master),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change 1 time unit after it, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic gap);
    if (gap) begin
      bit_en = 1'b0;
      tick();
    end
    serial = b;
    bit_en = 1'b1;
    tick();
  endtask

  // Start bit, 8 data bits LSB-first, parity bit, stop bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(s, gap);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    serial = 1'b1;
    bit_en = 1'b0;
    rx_if.out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_data",  32'(rx_if.out_data), 32'h00);
    check_eq("rst_valid", 32'(rx_if.out_valid), 32'd0);
    check_eq("rst_perr",  32'(parity_err), 32'd0);
    check_eq("rst_ferr",  32'(frame_err), 32'd0);
    check_eq("rst_ovf",   32'(overflow), 32'd0);
    reset = 1'b0;
    send_bit(1'b1, 1'b0);

    // 1: good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_eq("s1_valid", 32'(rx_if.out_valid), 32'd1);
    check_eq("s1_data",  32'(rx_if.out_data), 32'hA5);
    check_eq("s1_perr",  32'(parity_err), 32'd0);
    check_eq("s1_ferr",  32'(frame_err), 32'd0);
    send_bit(1'b1, 1'b0);
    check_eq("s1_pop",   32'(rx_if.out_valid), 32'd0);

    // 2: parity error, then good 0x0F
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_eq("s2_perr",  32'(parity_err), 32'd1);
    check_eq("s2_valid", 32'(rx_if.out_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    check_eq("s2_perr_pulse", 32'(parity_err), 32'd0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    check_eq("s2_valid2", 32'(rx_if.out_valid), 32'd1);
    check_eq("s2_data2",  32'(rx_if.out_data), 32'h0F);
    check_eq("s2_perr2",  32'(parity_err), 32'd0);
    send_bit(1'b1, 1'b0);

    // 3: framing error, then good 0x3C
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check_eq("s3_ferr",  32'(frame_err), 32'd1);
    check_eq("s3_perr",  32'(parity_err), 32'd0);
    check_eq("s3_valid", 32'(rx_if.out_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    check_eq("s3_ferr_pulse", 32'(frame_err), 32'd0);
    check_eq("s3_valid_idle", 32'(rx_if.out_valid), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("s3_valid2", 32'(rx_if.out_valid), 32'd1);
    check_eq("s3_data2",  32'(rx_if.out_data), 32'h3C);
    send_bit(1'b1, 1'b0);

    // 4: overflow with consumer stalled
    rx_if.out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("s4_valid1", 32'(rx_if.out_valid), 32'd1);
    check_eq("s4_data1",  32'(rx_if.out_data), 32'h3C);
    check_eq("s4_ovf1",   32'(overflow), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check_eq("s4_valid2", 32'(rx_if.out_valid), 32'd1);
    check_eq("s4_data2",  32'(rx_if.out_data), 32'h3C);
    check_eq("s4_ovf2",   32'(overflow), 32'd1);
    rx_if.out_ready = 1'b1;
    bit_en = 1'b0;
    tick();
    check_eq("s4_pop",    32'(rx_if.out_valid), 32'd0);
    check_eq("s4_ovf3",   32'(overflow), 32'd1);

    // 5: gapped stream, bit_en on alternate cycles
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check_eq("s5_valid", 32'(rx_if.out_valid), 32'd1);
    check_eq("s5_data",  32'(rx_if.out_data), 32'hA5);
    check_eq("s5_perr",  32'(parity_err), 32'd0);
    check_eq("s5_ferr",  32'(frame_err), 32'd0);
    bit_en = 1'b0;
    tick();
    check_eq("s5_pop",   32'(rx_if.out_valid), 32'd0);

    // 6: reset after four data bits, then a full 0x0F frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check_eq("s6_rst_data",  32'(rx_if.out_data), 32'h00);
    check_eq("s6_rst_valid", 32'(rx_if.out_valid), 32'd0);
    check_eq("s6_rst_ovf",   32'(overflow), 32'd0);
    check_eq("s6_rst_perr",  32'(parity_err), 32'd0);
    check_eq("s6_rst_ferr",  32'(frame_err), 32'd0);
    reset = 1'b0;
    serial = 1'b1;
    send_bit(1'b1, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    check_eq("s6_valid", 32'(rx_if.out_valid), 32'd1);
    check_eq("s6_data",  32'(rx_if.out_data), 32'h0F);
    check_eq("s6_perr",  32'(parity_err), 32'd0);
    check_eq("s6_ferr",  32'(frame_err), 32'd0);
    check_eq("s6_ovf",   32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
